// File: rtl/exc_pkg.sv
// Shared exception encodings and controller state type; maindec uses the same codes.
package exc_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    HANDLER = 2'd1,
    LOCK    = 2'd2
  } exc_state_t;

  localparam logic [3:0] EXC_NONE  = 4'b0000;
  localparam logic [3:0] EXC_IRQ   = 4'b0001;
  localparam logic [3:0] EXC_INVOP = 4'b0010;

endpackage

// File: rtl/exception_ctrl_irq_latch.sv
// External IRQ capture: arm/pend latch with one-cycle acknowledge per request level.
// Define IRQ_SYNC_EN to pass ExtIRQ through a 2-flop synchronizer first.
module irq_latch (
  input  logic clk,
  input  logic reset,
  input  logic ExtIRQ,
  input  logic take,
  output logic irq_pend,
  output logic ExtIAck
);

  logic irq_s;
  logic pend_q, pend_d;
  logic armed_q, armed_d;
  logic ack_q, ack_d;

`ifdef IRQ_SYNC_EN
  logic sync1_q, sync2_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= ExtIRQ;
      sync2_q <= sync1_q;
    end
  end

  assign irq_s = sync2_q;
`else
  assign irq_s = ExtIRQ;
`endif

  always_comb begin
    pend_d  = pend_q;
    armed_d = armed_q;
    if (irq_s && armed_q) begin
      pend_d  = 1'b1;
      armed_d = 1'b0;
    end
    if (!irq_s) armed_d = 1'b1;
    // A take on the same edge as a capture wins, leaving nothing pending.
    if (take) pend_d = 1'b0;
    ack_d = take;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_q  <= 1'b0;
      armed_q <= 1'b1;
      ack_q   <= 1'b0;
    end else begin
      pend_q  <= pend_d;
      armed_q <= armed_d;
      ack_q   <= ack_d;
    end
  end

  assign irq_pend = pend_q;
  assign ExtIAck  = ack_q;

endmodule

// File: rtl/exception_ctrl.sv
// Exception/interrupt controller: RUN/HANDLER/LOCK state, ELR/ESR, PC redirects.
// IRQ_SYNC_EN (see irq_latch) adds input synchronization on ExtIRQ.
module exception_ctrl
  import exc_pkg::*;
#(
  parameter int unsigned    N           = 64,
  parameter logic [N-1:0]   VECTOR_ADDR = 'hD8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [3:0]   EStatus,
  input  logic         ERet,
  input  logic         ExtIRQ,
  input  logic [N-1:0] imem_addr,
  output logic         irq_req,
  output logic         ExtIAck,
  output logic         Exc,
  output logic [N-1:0] ExcVector,
  output logic         ERetTaken,
  output logic [N-1:0] ELR,
  output logic [3:0]   ESR,
  output logic         Locked
);

  exc_state_t   state_q, state_d;
  logic [N-1:0] elr_q, elr_d;
  logic [3:0]   esr_q, esr_d;
  logic         irq_pend;
  logic         irq_take;

  assign irq_take = (state_q == RUN) && (EStatus == EXC_IRQ);

  irq_latch u_irq_latch (
    .clk      (clk),
    .reset    (reset),
    .ExtIRQ   (ExtIRQ),
    .take     (irq_take),
    .irq_pend (irq_pend),
    .ExtIAck  (ExtIAck)
  );

  always_comb begin
    state_d   = state_q;
    elr_d     = elr_q;
    esr_d     = esr_q;
    Exc       = 1'b0;
    ERetTaken = 1'b0;
    unique case (state_q)
      RUN: begin
        if (EStatus != EXC_NONE) begin
          Exc     = 1'b1;
          elr_d   = imem_addr;
          esr_d   = EStatus;
          state_d = HANDLER;
        end
      end
      HANDLER: begin
        // Any fault inside the handler is fatal, even alongside ERET.
        if (EStatus != EXC_NONE) begin
          state_d = LOCK;
        end else if (ERet) begin
          ERetTaken = 1'b1;
          state_d   = RUN;
        end
      end
      default: state_d = LOCK;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      elr_q   <= '0;
      esr_q   <= '0;
    end else begin
      state_q <= state_d;
      elr_q   <= elr_d;
      esr_q   <= esr_d;
    end
  end

  assign irq_req   = irq_pend && (state_q == RUN);
  assign Locked    = (state_q == LOCK);
  assign ExcVector = VECTOR_ADDR;
  assign ELR       = elr_q;
  assign ESR       = esr_q;

endmodule

// File: tb/tb_exception_ctrl.sv
// Directed self-checking bench for exception_ctrl.
module tb_exception_ctrl;

`ifdef IRQ_SYNC_EN
  localparam int unsigned LAT = 3;
`else
  localparam int unsigned LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  EStatus;
  logic        ERet;
  logic        ExtIRQ;
  logic [63:0] imem_addr;
  logic        irq_req, ExtIAck, Exc, ERetTaken, Locked;
  logic [63:0] ExcVector, ELR;
  logic [3:0]  ESR;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  exception_ctrl #(.N(64), .VECTOR_ADDR(64'hD8)) dut (
    .clk       (clk),
    .reset     (reset),
    .EStatus   (EStatus),
    .ERet      (ERet),
    .ExtIRQ    (ExtIRQ),
    .imem_addr (imem_addr),
    .irq_req   (irq_req),
    .ExtIAck   (ExtIAck),
    .Exc       (Exc),
    .ExcVector (ExcVector),
    .ERetTaken (ERetTaken),
    .ELR       (ELR),
    .ESR       (ESR),
    .Locked    (Locked)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks follow at +1.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; EStatus = 4'd0; ERet = 1'b0; ExtIRQ = 1'b0; imem_addr = 64'h0;
    #1 reset = 1'b0;
    #1;
    check("rst_elr", ELR, 64'h0);
    check("rst_esr", {60'h0, ESR}, 64'h0);
    check("rst_locked", {63'h0, Locked}, 64'h0);
    check("rst_ack", {63'h0, ExtIAck}, 64'h0);
    check("rst_irq_req", {63'h0, irq_req}, 64'h0);
    check("rst_vector", ExcVector, 64'hD8);
    #1 reset = 1'b1;
    tick();

    // Invalid opcode in RUN
    imem_addr = 64'h20; EStatus = 4'b0010; #1;
    check("invop_exc", {63'h0, Exc}, 64'h1);
    check("invop_vec", ExcVector, 64'hD8);
    tick();
    EStatus = 4'b0000; #1;
    check("invop_elr", ELR, 64'h20);
    check("invop_esr", {60'h0, ESR}, 64'h2);
    check("invop_irq_req", {63'h0, irq_req}, 64'h0);
    check("handler_no_exc", {63'h0, Exc}, 64'h0);
    ERet = 1'b1; #1;
    check("eret_taken", {63'h0, ERetTaken}, 64'h1);
    tick();

    // Stray ERET in RUN
    #1;
    check("stray_eret", {63'h0, ERetTaken}, 64'h0);
    check("stray_exc", {63'h0, Exc}, 64'h0);
    tick();
    ERet = 1'b0;

    // IRQ handshake
    ExtIRQ = 1'b1; #1;
    check("irq_req_early", {63'h0, irq_req}, 64'h0);
    for (int i = 1; i < LAT; i++) begin
      tick();
      check("irq_req_lat", {63'h0, irq_req}, 64'h0);
    end
    tick();
    check("irq_req_set", {63'h0, irq_req}, 64'h1);
    imem_addr = 64'h88; EStatus = 4'b0001; #1;
    check("irq_exc", {63'h0, Exc}, 64'h1);
    check("irq_ack_pre", {63'h0, ExtIAck}, 64'h0);
    tick();
    EStatus = 4'b0000; #1;
    check("irq_ack", {63'h0, ExtIAck}, 64'h1);
    check("irq_elr", ELR, 64'h88);
    check("irq_esr", {60'h0, ESR}, 64'h1);
    check("irq_req_handler", {63'h0, irq_req}, 64'h0);
    ERet = 1'b1;
    tick();
    ERet = 1'b0; #1;
    check("irq_ack_one", {63'h0, ExtIAck}, 64'h0);
    check("irq_pend_clr", {63'h0, irq_req}, 64'h0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("irq_held_no_req", {63'h0, irq_req}, 64'h0);
    end

    // Re-arm while in HANDLER; request must wait for RUN
    imem_addr = 64'h20; EStatus = 4'b0010;
    tick();
    EStatus = 4'b0000; ExtIRQ = 1'b0;
    for (int i = 0; i < LAT; i++) tick();
    ExtIRQ = 1'b1;
    for (int i = 0; i < LAT + 1; i++) begin
      tick();
      check("rearm_masked", {63'h0, irq_req}, 64'h0);
    end
    ERet = 1'b1; #1;
    check("rearm_eret", {63'h0, ERetTaken}, 64'h1);
    tick();
    ERet = 1'b0; #1;
    check("rearm_req", {63'h0, irq_req}, 64'h1);
    EStatus = 4'b0001;
    tick();
    EStatus = 4'b0000; #1;
    check("rearm_ack", {63'h0, ExtIAck}, 64'h1);
    check("rearm_elr", ELR, 64'h20);
    tick();

    // Double fault
    imem_addr = 64'h50; EStatus = 4'b0010; ERet = 1'b1; #1;
    check("dfault_exc", {63'h0, Exc}, 64'h0);
    check("dfault_eret", {63'h0, ERetTaken}, 64'h0);
    tick();
    EStatus = 4'b0000; #1;
    check("dfault_locked", {63'h0, Locked}, 64'h1);
    check("dfault_elr", ELR, 64'h20);
    check("dfault_esr", {60'h0, ESR}, 64'h1);
    check("lock_eret", {63'h0, ERetTaken}, 64'h0);
    EStatus = 4'b0010; #1;
    check("lock_exc", {63'h0, Exc}, 64'h0);
    tick();
    check("lock_hold", {63'h0, Locked}, 64'h1);
    check("lock_elr", ELR, 64'h20);
    check("lock_ack", {63'h0, ExtIAck}, 64'h0);
    check("lock_irq_req", {63'h0, irq_req}, 64'h0);

    // Async reset mid-HANDLER
    ERet = 1'b0; EStatus = 4'b0000; ExtIRQ = 1'b0;
    reset = 1'b0; #1 reset = 1'b1;
    tick();
    imem_addr = 64'h40; EStatus = 4'b0010;
    tick();
    EStatus = 4'b0000; #1;
    check("pre_rst_elr", ELR, 64'h40);
    #1 reset = 1'b0; #1;
    check("arst_elr", ELR, 64'h0);
    check("arst_esr", {60'h0, ESR}, 64'h0);
    check("arst_locked", {63'h0, Locked}, 64'h0);
    EStatus = 4'b0010; #1;
    check("arst_run_exc", {63'h0, Exc}, 64'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/exception_ctrl.md
Name: exception_ctrl

Overview:
- Exception/interrupt controller: the responder to the main decoder's exception signalling (EStatus, ERet) and the owner of the external IRQ handshake.
- Latches and arms external IRQ requests, presents a masked request to the decoder and holds the exception state: ELR, ESR and the current mode.
- Redirects the PC to the vector on exception entry and to ELR on ERET.
- Sits beside maindec and the PC mux in the single-cycle datapath.

Parameters:
- N, 64, address/data width.
- VECTOR_ADDR, 64'hD8, exception vector address driven on ExcVector.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- EStatus  input  4  exception status of the current instruction, from maindec; 0000 = none.
- ERet  input  1  current instruction is ERET, from maindec.
- ExtIRQ  input  1  external interrupt request, level, from the device.
- imem_addr  input  N  PC of the current instruction.
- irq_req  output  1  masked, latched IRQ request to maindec.
- ExtIAck  output  1  one-cycle acknowledge to the device.
- Exc  output  1  take exception this cycle; PC mux selects ExcVector.
- ExcVector  output  N  constant VECTOR_ADDR.
- ERetTaken  output  1  PC mux selects ELR this cycle.
- ELR  output  N  exception link register (faulting/interrupted PC).
- ESR  output  4  latched EStatus of the last exception taken.
- Locked  output  1  double fault; core must halt.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=RUN; ELR=0; ESR=0; Locked=0; ExtIAck=0.
  - irq_pend=0; armed=1.
- States: RUN, HANDLER, LOCK (encoded in the package).
- Combinational outputs:
  - Exc = (state==RUN) & (EStatus!=0).
  - ERetTaken = (state==HANDLER) & ERet & (EStatus==0).
  - irq_req = irq_pend & (state==RUN).
  - Locked = (state==LOCK).
- RUN:
  - EStatus!=0 -> on next edge ELR<=imem_addr, ESR<=EStatus, state<=HANDLER.
  - If EStatus==EXC_IRQ (0001), also irq_pend<=0 and ExtIAck<=1 for exactly one cycle.
  - ERet in RUN is ignored: no redirect, no state change.
- HANDLER:
  - irq_req forced 0; ELR/ESR hold.
  - ERetTaken -> state<=RUN on next edge; irq_req may reassert in the first RUN cycle.
  - EStatus!=0 (any code, including ERet coincident with it) -> state<=LOCK; Exc stays 0.
- LOCK:
  - Absorbing; only reset exits.
  - All redirects 0; ExtIAck 0; ELR/ESR frozen.
- IRQ latch:
  - ExtIRQ=1 & armed -> irq_pend<=1, armed<=0.
  - armed<=1 only when ExtIRQ is sampled 0, so one ack is given per request level.
  - A device that holds ExtIRQ high after ExtIAck gets no second interrupt.
- Simultaneous events:
  - IRQ capture and IRQ take on the same edge: the take wins; irq_pend ends 0.
  - A new ExtIRQ while irq_pend=1 is absorbed, because armed=0.
- Latency:
  - Exception redirect: same cycle (combinational).
  - ELR/ESR valid: cycle after Exc.
  - ExtIAck: cycle after IRQ take.
  - ExtIRQ rise -> irq_req: 1 cycle.

Optional Feature:
- IRQ_SYNC_EN defined: ExtIRQ passes through a 2-flop synchronizer (reset to 0) before the latch. ExtIRQ rise -> irq_req becomes 3 cycles.
- Undefined: ExtIRQ is sampled directly; latency is 1 cycle.
- All other behaviour is identical either way.

Decomposition:
- Package exc_pkg holds:
  - typedef enum logic [1:0] exc_state_t {RUN, HANDLER, LOCK}.
  - localparams EXC_NONE=4'b0000, EXC_IRQ=4'b0001, EXC_INVOP=4'b0010.
  - maindec uses the same constants.
- One natural sub-module: irq_latch (optional synchronizer, armed/pend logic, ExtIAck pulse). The state machine and ELR/ESR registers stay in exception_ctrl.

Test Plan:
- Reset: drive reset=0 mid-HANDLER with ELR=0x40 -> state RUN, ELR=0, ESR=0, all outputs 0 immediately, without waiting for clk.
- Invalid opcode: RUN, imem_addr=0x20, EStatus=0010 -> Exc=1 and ExcVector=0xD8 same cycle; next cycle ELR=0x20, ESR=0010, irq_req=0. Then ERet=1 -> ERetTaken=1; next cycle state RUN.
- IRQ handshake: ExtIRQ=1 -> irq_req=1 after 1 cycle (3 with IRQ_SYNC_EN). Drive EStatus=0001 at imem_addr=0x88 -> ExtIAck=1 for exactly one cycle, ELR=0x88, irq_pend=0. Hold ExtIRQ=1 for 5 more cycles -> no second irq_req.
- Re-arm: drop ExtIRQ 1 cycle, ERET, raise again -> irq_req reasserts only once RUN is re-entered.
- Double fault: in HANDLER with ELR=0x20, EStatus=0010 -> Exc=0; next cycle Locked=1. ERet=1 thereafter -> ERetTaken=0; ELR stays 0x20.
- Stray ERET: ERet=1 in RUN -> ERetTaken=0, Exc=0, state unchanged.
